// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port integer register file for the ID
//               stage. It has N combinational read ports and M write ports.
//               A clear sequencer zeroes the array after reset or when
//               clear_req is pulsed. x0 always reads as zero.
//               Optional macro REGFILE_BYPASS_EN turns on same-cycle
//               write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_req,
  output logic                                 ready,
  input  logic [NUM_RD_PORTS*$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS*$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] C_LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] C_IDX_ONE  = AW'(1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_clr_idx;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  assign ready = r_ready;

  // Clear sequencer: walk every entry once, then sit in IDLE until asked again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_idx == C_LAST_IDX) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + C_IDX_ONE;
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_idx <= '0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Array update: sequencer zeroes while clearing, ports write only when idle;
  // later ports overwrite earlier ones so the highest index wins on a collision
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          r_mem[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_addr = rd_addr[p*AW +: AW];

    // Read mux: array value, optionally forwarded write data, forced to zero
    // for x0 or while the array is being cleared
    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == w_addr)) begin
          w_data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`else
`endif
      if (!r_ready || (w_addr == '0)) begin
        w_data = '0;
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp with two read
//               ports and two write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic               clk;
  logic               rst_n;
  logic               clear_req;
  logic               ready;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NR),
    .NUM_RD_PORTS(NRD),
    .NUM_WR_PORTS(NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(clear_req),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Read one port combinationally
  task automatic rd(input int port, input logic [AW-1:0] addr, output logic [DW-1:0] data);
    rd_addr[port*AW +: AW] = addr;
    #1;
    data = rd_data[port*DW +: DW];
  endtask

  // Single write on port 0, committed at the next posedge
  task automatic wr0(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en = 2'b01;
    wr_addr[0 +: AW] = addr;
    wr_data[0 +: DW] = data;
    @(negedge clk);
    wr_en = 2'b00;
  endtask

  // Count posedges until ready rises, bounded
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  int            n;

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;

    // 1: reset and initial clear
    repeat (2) @(negedge clk);
    rd_addr = {5'd3, 5'd1};
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_rd", {32'd0, rd_data}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_ready", {63'd0, ready}, 64'd0);
    wait_ready(n);
    check("init_clear_cycles", 64'(n), 64'd32);
    for (int a = 1; a < NR; a++) begin
      rd(a % 2, a[AW-1:0], d0);
      check($sformatf("init_zero_x%0d", a), {32'd0, d0}, 64'd0);
    end

    // 2: consecutive writes and x0 discard
    @(negedge clk);
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd1; wr_data[0 +: DW] = 32'd100;
    @(negedge clk);
    wr_addr[0 +: AW] = 5'd2; wr_data[0 +: DW] = 32'd50;
    @(negedge clk);
    wr_en = 2'b00;
    rd_addr = {5'd2, 5'd1};
    #1;
    check("read_p1_x2", {32'd0, rd_data[DW +: DW]}, 64'd50);
    check("read_p0_x1", {32'd0, rd_data[0 +: DW]}, 64'd100);
    @(negedge clk);
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: DW] = 32'hDEADBEEF;
    rd(0, 5'd0, d0);
    check("x0_same_cycle", {32'd0, d0}, 64'd0);
    @(negedge clk);
    wr_en = 2'b00;
    rd(0, 5'd0, d0);
    check("x0_after_write", {32'd0, d0}, 64'd0);

    // 3: write and read of x3 in the same cycle
    @(negedge clk);
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: DW] = 32'd150;
    rd(0, 5'd3, d0);
`ifdef REGFILE_BYPASS_EN
    check("x3_same_cycle", {32'd0, d0}, 64'd150);
`else
    check("x3_same_cycle", {32'd0, d0}, 64'd0);
`endif
    @(negedge clk);
    wr_en = 2'b00;
    rd(0, 5'd3, d0);
    check("x3_next_cycle", {32'd0, d0}, 64'd150);

    // 4: both ports write x5, port 1 wins
    @(negedge clk);
    wr_en = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {32'h22, 32'h11};
    rd(1, 5'd5, d1);
`ifdef REGFILE_BYPASS_EN
    check("x5_same_cycle", {32'd0, d1}, 64'h22);
`else
    check("x5_same_cycle", {32'd0, d1}, 64'd0);
`endif
    @(negedge clk);
    wr_en = 2'b00;
    rd(1, 5'd5, d1);
    check("x5_collision", {32'd0, d1}, 64'h22);

    // 5: clear request with x4 populated, dropped write, ignored re-pulse
    wr0(5'd4, 32'd200);
    rd(0, 5'd4, d0);
    check("x4_written", {32'd0, d0}, 64'd200);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    check("clear_ready_low", {63'd0, ready}, 64'd0);
    check("clear_rd_forced0", {32'd0, rd_data[0 +: DW]}, 64'd0);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd6; wr_data[0 +: DW] = 32'd77;
      end
      if (n == 10) clear_req = 1'b1;
      if (n == 11) clear_req = 1'b0;
      if (n == 15) wr_en = 2'b00;
    end
    check("clear_cycles", 64'(n), 64'd32);
    rd(0, 5'd4, d0);
    check("x4_cleared", {32'd0, d0}, 64'd0);
    rd(1, 5'd6, d1);
    check("x6_dropped", {32'd0, d1}, 64'd0);

    // 6: reset in the middle of a clear restarts it
    wr0(5'd20, 32'h1234);
    rd(0, 5'd20, d0);
    check("x20_written", {32'd0, d0}, 64'h1234);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_clear_idx", {59'd0, dut.r_clr_idx}, 64'd10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_idx", {59'd0, dut.r_clr_idx}, 64'd0);
    check("rst_mid_ready", {63'd0, ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("restart_cycles", 64'(n), 64'd32);
    rd(0, 5'd20, d0);
    check("x20_cleared", {32'd0, d0}, 64'd0);
    wr0(5'd9, 32'hCAFE);
    rd(1, 5'd9, d1);
    check("x9_after_restart", {32'd0, d1}, 64'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
